// File: rtl/sc_mul_acc_pkg.sv
// Shared types and helpers for the stochastic multiplier: FSM states,
// Sobol direction numbers and stream-length clamping.
package sc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } sc_state_e;

   // Direction number V[k]; indices at or past width contribute nothing.
   function automatic logic [31:0] sobol_dir(input int width, input int dim, input int k);
      logic [31:0] m;
      m = 32'd1;
      for (int j = 0; j < k; j++) begin
         m = m ^ (m << 1);
      end
      if (k >= width) begin
         return 32'd0;
      end else if (dim == 1) begin
         return 32'd1 << (width - 1 - k);
      end else begin
         return m << (width - 1 - k);
      end
   endfunction

   function automatic int clamp_len(input int len, input int width);
      return (len > width) ? width : len;
   endfunction

endpackage

// File: rtl/sc_mul_acc_rng.sv
// Gray-code Sobol sequence generator for one dimension (DIM 1 or 2).
module sc_sobol_rng
   import sc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIM   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             iEnable,
   input  logic             iClear,
   output logic [WIDTH-1:0] oSeq
);

   logic [WIDTH-1:0] r_idx;
   logic [WIDTH-1:0] r_seq;
   logic [WIDTH-1:0] w_dir;
   logic [WIDTH-1:0] w_vtab [WIDTH+1];

   for (genvar g = 0; g <= WIDTH; g++) begin : g_dir
      assign w_vtab[g] = WIDTH'(sobol_dir(WIDTH, DIM, g));
   end

   // Direction selected by the lowest zero bit of the index (trailing-ones count).
   always_comb begin
      w_dir = w_vtab[WIDTH];
      for (int k = WIDTH - 1; k >= 0; k--) begin
         if (!r_idx[k]) begin
            w_dir = w_vtab[k];
         end else begin
            w_dir = w_dir;
         end
      end
   end

   // Index and sequence state; clear wins over advance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
         r_seq <= '0;
      end else if (iClear) begin
         r_idx <= '0;
         r_seq <= '0;
      end else if (iEnable) begin
         r_idx <= r_idx + WIDTH'(1);
         r_seq <= r_seq ^ w_dir;
      end
   end

   assign oSeq = r_seq;

endmodule

// File: rtl/sc_mul_acc.sv
// Stochastic multiplier with a built-in ones counter over 2^L cycles.
// Define SC_BIPOLAR_EN to add the iBipolar port (XNOR bipolar product).
module sc_mul_acc
   import sc_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   input  logic [LW-1:0]    iLenLog2,
   input  logic             iStart,
`ifdef SC_BIPOLAR_EN
   input  logic             iBipolar,
`endif
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH:0]   oCount,
   output logic             oBit
);

   sc_state_e        r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [LW-1:0]    r_len;
   logic [WIDTH:0]   r_cnt;
   logic [WIDTH:0]   r_cyc;
   logic [WIDTH:0]   r_count;
`ifdef SC_BIPOLAR_EN
   logic             r_bip;
`endif

   logic [WIDTH-1:0] w_seq_a;
   logic [WIDTH-1:0] w_seq_b;
   logic             w_bit_a;
   logic             w_bit_b;
   logic             w_prod;
   logic             w_start;
   logic             w_run;
   logic             w_last;
   logic [WIDTH:0]   w_term;
   logic [WIDTH:0]   w_cnt_next;

   assign w_run   = (r_state == ST_RUN);
   assign w_start = iStart & ~w_run;

   sc_sobol_rng #(.WIDTH(WIDTH), .DIM(1)) u_rng_a (
      .clk(clk), .rst(rst), .iEnable(w_run), .iClear(w_start), .oSeq(w_seq_a)
   );

   sc_sobol_rng #(.WIDTH(WIDTH), .DIM(2)) u_rng_b (
      .clk(clk), .rst(rst), .iEnable(w_run), .iClear(w_start), .oSeq(w_seq_b)
   );

   assign w_bit_a = (r_a > w_seq_a);
   assign w_bit_b = (r_b > w_seq_b);
`ifdef SC_BIPOLAR_EN
   assign w_prod = r_bip ? ~(w_bit_a ^ w_bit_b) : (w_bit_a & w_bit_b);
`else
   assign w_prod = w_bit_a & w_bit_b;
`endif
   assign oBit = w_run & w_prod;

   assign w_term     = ((WIDTH+1)'(1) << r_len) - (WIDTH+1)'(1);
   assign w_last     = (r_cyc == w_term);
   assign w_cnt_next = r_cnt + {{WIDTH{1'b0}}, oBit};

   // Control FSM with operand latching, ones counting and result capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_len   <= '0;
         r_cnt   <= '0;
         r_cyc   <= '0;
         r_count <= '0;
`ifdef SC_BIPOLAR_EN
         r_bip   <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (iStart) begin
                  r_a     <= iA;
                  r_b     <= iB;
                  r_len   <= LW'(clamp_len(int'(iLenLog2), WIDTH));
`ifdef SC_BIPOLAR_EN
                  r_bip   <= iBipolar;
`endif
                  r_cnt   <= '0;
                  r_cyc   <= '0;
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_cnt <= w_cnt_next;
               r_cyc <= r_cyc + (WIDTH+1)'(1);
               if (w_last) begin
                  r_count <= w_cnt_next;
                  r_state <= ST_DONE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign oBusy  = w_run;
   assign oDone  = (r_state == ST_DONE);
   assign oCount = r_count;

endmodule

// File: tb/tb_sc_mul_acc.sv
// Self-checking bench for sc_mul_acc (WIDTH=8): directed plan steps plus
// randomized runs against a plain-arithmetic Sobol reference model.
module tb_sc_mul_acc;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] iA, iB;
   logic [3:0] iLenLog2;
   logic       iStart;
   logic       iBipolar;
   logic       oBusy, oDone, oBit;
   logic [8:0] oCount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sc_mul_acc #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .iA(iA), .iB(iB), .iLenLog2(iLenLog2), .iStart(iStart),
`ifdef SC_BIPOLAR_EN
      .iBipolar(iBipolar),
`endif
      .oBusy(oBusy), .oDone(oDone), .oCount(oCount), .oBit(oBit)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Counts ones of the Sobol product stream using the recurrence directly.
   function automatic int model_count(input int a, input int b, input int l, input bit bip);
      int v1[8];
      int v2[8];
      int m, x1, x2, cnt, c, lc;
      bit ba, bb;
      m = 1; x1 = 0; x2 = 0; cnt = 0;
      lc = (l > 8) ? 8 : l;
      for (int k = 0; k < 8; k++) begin
         v1[k] = 1 << (7 - k);
         v2[k] = m << (7 - k);
         m = m ^ (m << 1);
      end
      for (int n = 0; n < (1 << lc); n++) begin
         ba = (a > x1);
         bb = (b > x2);
         cnt += bip ? int'(ba == bb) : int'(ba & bb);
         c = 0;
         while (c < 8 && ((n >> c) & 1) == 1) c++;
         if (c < 8) begin
            x1 ^= v1[c];
            x2 ^= v2[c];
         end
      end
      return cnt;
   endfunction

   task automatic wait_done(output int cycles, output int ones, output int busy);
      cycles = 1; ones = 0; busy = 0;
      while (!oDone && cycles < 400) begin
         if (oBusy) begin
            busy++;
            ones += int'(oBit);
         end
         @(posedge clk); #1;
         cycles++;
      end
   endtask

   task automatic run_check(input int a, input int b, input int l, input bit bip,
                            input int exp, input string tag);
      int cycles, ones, busy, lc, prev;
      lc = (l > 8) ? 8 : l;
      prev = int'(oCount);
      iA = 8'(a); iB = 8'(b); iLenLog2 = 4'(l); iBipolar = bip; iStart = 1'b1;
      @(posedge clk); #1;
      iStart = 1'b0;
      chk({tag, "_hold"}, int'(oCount), prev);
      wait_done(cycles, ones, busy);
      chk({tag, "_lat"}, cycles, (1 << lc) + 1);
      chk({tag, "_busy"}, busy, 1 << lc);
      chk({tag, "_bits"}, ones, exp);
      chk({tag, "_cnt"}, int'(oCount), exp);
      chk({tag, "_donebusy"}, int'(oBusy), 0);
      @(posedge clk); #1;
      chk({tag, "_pulse"}, int'(oDone), 0);
   endtask

   initial begin
      int cycles, ones, busy, dones, a, b, l, exp;
      rst = 1'b1; iA = 8'd0; iB = 8'd0; iLenLog2 = 4'd0; iStart = 1'b0; iBipolar = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", int'(oBusy), 0);
      chk("rst_done", int'(oDone), 0);
      chk("rst_count", int'(oCount), 0);
      chk("rst_bit", int'(oBit), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_check(0, 200, 8, 1'b0, 0, "a0");
      run_check(128, 128, 8, 1'b0, 64, "half8");
      run_check(128, 128, 4, 1'b0, 4, "half4");
      run_check(255, 255, 0, 1'b0, 1, "full0");
      run_check(128, 128, 15, 1'b0, 64, "clamp");

      // iStart held through RUN: operand change ignored, restart from DONE.
      iA = 8'd255; iB = 8'd255; iLenLog2 = 4'd2; iStart = 1'b1;
      @(posedge clk); #1;
      iA = 8'd0;
      wait_done(cycles, ones, busy);
      chk("held_lat", cycles, 5);
      chk("held_cnt", int'(oCount), model_count(255, 255, 2, 1'b0));
      @(posedge clk); #1;
      iStart = 1'b0;
      chk("b2b_busy", int'(oBusy), 1);
      chk("b2b_hold", int'(oCount), 4);
      wait_done(cycles, ones, busy);
      chk("b2b_lat", cycles, 5);
      chk("b2b_cnt", int'(oCount), model_count(0, 255, 2, 1'b0));

      run_check(128, 128, 3, 1'b0, 2, "half3");

      // Reset in the middle of a run.
      iA = 8'd128; iB = 8'd128; iLenLog2 = 4'd8; iStart = 1'b1;
      @(posedge clk); #1;
      iStart = 1'b0;
      repeat (99) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("mid_busy", int'(oBusy), 0);
      chk("mid_count", int'(oCount), 0);
      chk("mid_bit", int'(oBit), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 300; i++) begin
         dones += int'(oDone);
         @(posedge clk); #1;
      end
      chk("mid_nodone", dones, 0);
      run_check(128, 128, 8, 1'b0, 64, "post_rst");

`ifdef SC_BIPOLAR_EN
      run_check(128, 128, 8, 1'b1, 128, "bipolar");
      run_check(200, 40, 6, 1'b1, model_count(200, 40, 6, 1'b1), "bip_rnd");
`else
      run_check(128, 128, 8, 1'b1, 64, "unipolar");
`endif

      for (int i = 0; i < 12; i++) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         l = int'($urandom_range(0, 15));
         exp = model_count(a, b, l, 1'b0);
         run_check(a, b, l, 1'b0, exp, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sc_mul_acc.md
# sc_mul_acc

Parametrised stochastic-computing multiplier with a built-in result counter. It latches two WIDTH-bit unsigned operands on a start handshake and generates one product bit per cycle from two decorrelated Sobol streams: dimension 1 for A and dimension 2 for B. It counts the ones over a run-time-selectable stream length of 2^L cycles and returns the binary count with a done pulse. It sits between the operand loaders and the accuracy-measurement logic, replacing the fixed-width, free-running, bit-output-only multiplier.

## Interface
- WIDTH, 8: operand and RNG width in bits; maximum stream length is 2^WIDTH.
- LW, $clog2(WIDTH+1): width of the stream-length select.
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- iA  input  WIDTH  operand A, unsigned; probability is iA/2^WIDTH.
- iB  input  WIDTH  operand B, unsigned.
- iLenLog2  input  LW  L, the log2 of the stream length; values above WIDTH clamp to WIDTH.
- iStart  input  1  start request; sampled when not busy.
- oBusy  output  1  high while a stream is running.
- oDone  output  1  one-cycle pulse when oCount becomes valid.
- oCount  output  WIDTH+1  number of ones in the product stream.
- oBit  output  1  current product bit; qualified by oBusy.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE or DONE with iStart=1:
  - latch iA, iB and min(iLenLog2, WIDTH);
  - clear the counter and both RNGs;
  - go to RUN.
- RUN:
  - each cycle, bitA = (A_buf > seqA) and bitB = (B_buf > seqB), strict compare;
  - oBit = bitA & bitB;
  - counter += oBit;
  - RNGs advance;
  - the cycle counter reaches 2^L - 1 -> go to DONE.
- DONE: oDone=1 for one cycle, then IDLE. If iStart=1 in DONE, go straight to RUN; oDone is still 1 that cycle.
- oCount updates only on the RUN->DONE transition. It holds until the next run's DONE and is not cleared by a new start.
- iStart while in RUN is ignored; operands are not re-latched.
- RNG is a Gray-code Sobol generator with index n and sequence x.
  - x0 = 0.
  - x(n+1) = x(n) ^ V[c], where c = number of trailing ones of n.
  - Dim 1: V[k] = 1 << (WIDTH-1-k).
  - Dim 2: V[k] = m(k+1) << (WIDTH-1-k), with m1=1 and m(j) = m(j-1) ^ (m(j-1)<<1), giving 1, 3, 5, 15, 17, 51, 85, 255, ...
- Arithmetic: the counter is WIDTH+1 bits, so the maximum 2^WIDTH does not overflow. The cycle counter is WIDTH+1 bits.
- L = 0 gives a 1-cycle stream; oCount is 0 or 1.

## Timing
- Reset values: oBusy=0, oDone=0, oCount=0, oBit=0. State=IDLE; operand buffers, RNGs and counters = 0.
- iStart sampled high at edge t -> oBusy=1 from t+1 through t+2^L.
- Cycle t+1 uses RNG index 0.
- oDone=1 and oCount valid in cycle t+2^L+1. Total latency is 2^L+1 cycles.
- oBit is combinational from registered operands and RNG state; it is 0 when not in RUN.
- Reset asserted mid-run: immediate return to reset values. No oDone is issued and the partial count is discarded.

## Configuration
- SC_BIPOLAR_EN defined:
  - adds input port iBipolar (1 bit), latched at start;
  - iBipolar=1: oBit = XNOR(bitA, bitB), the bipolar product of (2A/2^W - 1)(2B/2^W - 1);
  - iBipolar=0: AND as above.
- SC_BIPOLAR_EN undefined: no iBipolar port; unipolar AND only.

## Structure
- Package sc_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - function sobol_dir(width, dim, k) returning V[k];
  - the clamp function for L.
- Sub-module sc_sobol_rng:
  - parameters WIDTH and DIM (1 or 2);
  - ports clk, rst, iEnable, iClear, oSeq;
  - iClear has priority over iEnable;
  - instantiated twice.

## Test plan
- WIDTH=8: reset, then check all outputs are 0. Start with A=0, B=200, L=8 -> oDone at cycle 257 after start, oCount=0.
- A=128, B=128, L=8 -> oCount=64. A=128, B=128, L=4 -> oCount=4 with oDone at cycle 17.
- A=255, B=255, L=0 -> oCount=1. iStart held high through RUN is ignored, and a new run starts from DONE back-to-back.
- Reset mid-run at cycle 100 -> no oDone, oCount=0. A following run with A=128, B=128, L=8 gives 64.
- SC_BIPOLAR_EN with iBipolar=1, A=128, B=128, L=8 -> oCount=128. With the macro off, the same stimulus gives 64.
- Random operands and L: oCount matches a bit-exact model built from the sobol_dir function.
